decode_control_sequencer: RTL and testbench

- Multi-cycle instruction decoder and sequencer on the producer side of the decode-stage control register.
- Accepts one instruction word per handshake and decodes its opcode.
- Emits registered one-bit control strobes (AR load, BR load, ALU enable, input select, write enable), plus ALU op and address, one beat at a time.
- Honours a downstream STALL and sits between instruction fetch and the decode pipeline register.

---
 rtl/decode_pkg.sv | 42 ++++
 rtl/decode_lut.sv | 40 ++++
 rtl/decode_control_sequencer.sv | 153 +++++++++++++++
 tb/tb_decode_control_sequencer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared definitions for the decode-stage sequencer: opcodes, ALU codes,
// FSM states and the strobe / lookup record layouts.
package decode_pkg;

   localparam logic [3:0] OP_NOP  = 4'd0;
   localparam logic [3:0] OP_LDA  = 4'd1;
   localparam logic [3:0] OP_LDB  = 4'd2;
   localparam logic [3:0] OP_ADD  = 4'd3;
   localparam logic [3:0] OP_SUB  = 4'd4;
   localparam logic [3:0] OP_IN   = 4'd5;
   localparam logic [3:0] OP_ST   = 4'd6;
   localparam logic [3:0] OP_HALT = 4'd7;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DECODE = 2'd1,
      S_ISSUE  = 2'd2,
      S_HALT   = 2'd3
   } state_t;

   // Strobe ordering {AR, BR, ALU, INPUT, WREN}, MSB first.
   typedef struct packed {
      logic ar;
      logic br;
      logic alu;
      logic inp;
      logic wren;
   } strobe_t;

   // Per-opcode decode record. beats = 0 for NOP, HALT and illegal codes.
   typedef struct packed {
      logic [1:0] beats;
      strobe_t    beat1;
      strobe_t    beat2;
      logic [2:0] alu_op;
      logic       illegal;
   } lut_t;

endpackage

// File: rtl/decode_lut.sv
// Combinational opcode table: beat count, strobes of each beat, ALU op and
// illegal flag. No state; the sequencer owns all registers.
module decode_lut
   import decode_pkg::*;
(
   input  logic [3:0] opcode_i,
   output lut_t       info_o
);

   // Opcode to beat description; anything above HALT is undefined.
   always_comb begin
      info_o = '0;
      case (opcode_i)
         OP_NOP:  info_o.beats = 2'd0;
         OP_LDA:  begin info_o.beats = 2'd1; info_o.beat1.ar   = 1'b1; end
         OP_LDB:  begin info_o.beats = 2'd1; info_o.beat1.br   = 1'b1; end
         OP_ADD:  begin
            info_o.beats     = 2'd2;
            info_o.beat1.alu = 1'b1;
            info_o.beat2.ar  = 1'b1;
            info_o.alu_op    = ALU_ADD;
         end
         OP_SUB:  begin
            info_o.beats     = 2'd2;
            info_o.beat1.alu = 1'b1;
            info_o.beat2.ar  = 1'b1;
            info_o.alu_op    = ALU_SUB;
         end
         OP_IN:   begin
            info_o.beats     = 2'd1;
            info_o.beat1.inp = 1'b1;
            info_o.beat1.ar  = 1'b1;
         end
         OP_ST:   begin info_o.beats = 2'd1; info_o.beat1.wren = 1'b1; end
         OP_HALT: info_o.beats = 2'd0;
         default: info_o.illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/decode_control_sequencer.sv
// Decode-stage sequencer: accepts one instruction per handshake, decodes it
// and plays out up to two registered strobe beats, holding each under STALL.
module decode_control_sequencer
   import decode_pkg::*;
#(
   parameter  int INSTR_W = 16,
   localparam int ADDR_W  = INSTR_W - 4
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic [INSTR_W-1:0] INSTR_IN,
   input  logic               INSTR_VALID,
   output logic               INSTR_READY,
   input  logic               STALL,
   output logic               ISSUE_VALID,
   output logic               AR_EN,
   output logic               BR_EN,
   output logic               ALU_EN,
   output logic               INPUT_EN,
   output logic               WREN,
   output logic [2:0]         ALU_OP,
   output logic [ADDR_W-1:0]  ADDR,
   output logic               ILLEGAL,
   output logic               HALTED
);

   state_t              state_q, state_d;
   logic [INSTR_W-1:0]  instr_q, instr_d;
   logic                beat2_q, beat2_d;   // currently showing the second beat
   logic                ready_q, ready_d;
   logic                valid_q, valid_d;
   strobe_t             stb_q, stb_d;
   logic [2:0]          alu_op_q, alu_op_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                illegal_q, illegal_d;
   logic                halted_q, halted_d;

   logic [3:0]          opcode;
   logic [ADDR_W-1:0]   operand;
   lut_t                info;

   assign opcode  = instr_q[INSTR_W-1 -: 4];
   assign operand = instr_q[ADDR_W-1:0];

   // The captured word stays in instr_q for the whole instruction, so the
   // table output is stable across both beats.
   decode_lut u_lut (
      .opcode_i (opcode),
      .info_o   (info)
   );

   // Next state and next values of every output register; default is hold.
   always_comb begin
      state_d   = state_q;
      instr_d   = instr_q;
      beat2_d   = beat2_q;
      valid_d   = valid_q;
      stb_d     = stb_q;
      alu_op_d  = alu_op_q;
      addr_d    = addr_q;
      illegal_d = 1'b0;
      halted_d  = halted_q;

      case (state_q)
         S_IDLE: begin
            if (INSTR_VALID && ready_q) begin
               instr_d = INSTR_IN;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            if (info.illegal) begin
               illegal_d = 1'b1;
               state_d   = S_IDLE;
            end else if (opcode == OP_HALT) begin
               halted_d = 1'b1;
               state_d  = S_HALT;
            end else if (info.beats == 2'd0) begin
               state_d = S_IDLE;
            end else begin
               valid_d  = 1'b1;
               stb_d    = info.beat1;
               alu_op_d = info.beat1.alu ? info.alu_op : '0;
               addr_d   = operand;
               beat2_d  = 1'b0;
               state_d  = S_ISSUE;
            end
         end
         S_ISSUE: begin
            // A stalled beat simply holds every register.
            if (!STALL) begin
               if (!beat2_q && info.beats == 2'd2) begin
                  // Swap straight to beat 2; ISSUE_VALID and ADDR stay up.
                  beat2_d  = 1'b1;
                  stb_d    = info.beat2;
                  alu_op_d = info.beat2.alu ? info.alu_op : '0;
               end else begin
                  valid_d  = 1'b0;
                  stb_d    = '0;
                  alu_op_d = '0;
                  addr_d   = '0;
                  beat2_d  = 1'b0;
                  state_d  = S_IDLE;
               end
            end
         end
         S_HALT: halted_d = 1'b1;
         default: state_d = S_IDLE;
      endcase

      ready_d = (state_d == S_IDLE);
   end

   // State and output registers; reset wins over everything, HALT included.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= S_IDLE;
         instr_q   <= '0;
         beat2_q   <= 1'b0;
         ready_q   <= 1'b0;
         valid_q   <= 1'b0;
         stb_q     <= '0;
         alu_op_q  <= '0;
         addr_q    <= '0;
         illegal_q <= 1'b0;
         halted_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         instr_q   <= instr_d;
         beat2_q   <= beat2_d;
         ready_q   <= ready_d;
         valid_q   <= valid_d;
         stb_q     <= stb_d;
         alu_op_q  <= alu_op_d;
         addr_q    <= addr_d;
         illegal_q <= illegal_d;
         halted_q  <= halted_d;
      end
   end

   assign INSTR_READY = ready_q;
   assign ISSUE_VALID = valid_q;
   assign AR_EN       = stb_q.ar;
   assign BR_EN       = stb_q.br;
   assign ALU_EN      = stb_q.alu;
   assign INPUT_EN    = stb_q.inp;
   assign WREN        = stb_q.wren;
   assign ALU_OP      = alu_op_q;
   assign ADDR        = addr_q;
   assign ILLEGAL     = illegal_q;
   assign HALTED      = halted_q;

endmodule

// File: tb/tb_decode_control_sequencer.sv
// Scoreboard bench: a reference model turns each accepted instruction into
// expected events; a negedge monitor pops and compares them as they appear.
module tb_decode_control_sequencer;

   localparam int INSTR_W = 16;
   localparam int ADDR_W  = 12;

   logic               CLK = 1'b0;
   logic               RST;
   logic [INSTR_W-1:0] INSTR_IN;
   logic               INSTR_VALID;
   logic               INSTR_READY;
   logic               STALL;
   logic               ISSUE_VALID, AR_EN, BR_EN, ALU_EN, INPUT_EN, WREN;
   logic [2:0]         ALU_OP;
   logic [ADDR_W-1:0]  ADDR;
   logic               ILLEGAL, HALTED;

   decode_control_sequencer #(.INSTR_W(INSTR_W)) dut (
      .CLK(CLK), .RST(RST), .INSTR_IN(INSTR_IN), .INSTR_VALID(INSTR_VALID),
      .INSTR_READY(INSTR_READY), .STALL(STALL), .ISSUE_VALID(ISSUE_VALID),
      .AR_EN(AR_EN), .BR_EN(BR_EN), .ALU_EN(ALU_EN), .INPUT_EN(INPUT_EN),
      .WREN(WREN), .ALU_OP(ALU_OP), .ADDR(ADDR), .ILLEGAL(ILLEGAL),
      .HALTED(HALTED)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   typedef enum {K_BEAT, K_ILL, K_HALT} kind_e;
   typedef struct {
      kind_e       kind;
      logic [4:0]  stb;    // {AR, BR, ALU, INPUT, WREN}
      logic [2:0]  op;
      logic [11:0] addr;
      int          due;    // cycle of first appearance, -1 = not timed
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;
   int   beat_cycles = 0;
   bit   mon_en = 0;
   bit   rnd_stall = 0;
   bit   halt_seen = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: instruction word -> expected events, straight from the opcode table.
   task automatic model(input logic [15:0] w, input int due);
      exp_t e;
      logic [3:0] op;
      op     = w[15:12];
      e.kind = K_BEAT;
      e.stb  = 5'b0;
      e.op   = 3'b0;
      e.addr = w[11:0];
      e.due  = due;
      case (op)
         4'd0: ;
         4'd1: begin e.stb = 5'b10000; q.push_back(e); end
         4'd2: begin e.stb = 5'b01000; q.push_back(e); end
         4'd3, 4'd4: begin
            e.stb = 5'b00100; e.op = (op == 4'd3) ? 3'b000 : 3'b001; q.push_back(e);
            e.stb = 5'b10000; e.op = 3'b000; e.due = -1; q.push_back(e);
         end
         4'd5: begin e.stb = 5'b10010; q.push_back(e); end
         4'd6: begin e.stb = 5'b00001; q.push_back(e); end
         4'd7: begin e.kind = K_HALT; e.addr = 0; q.push_back(e); end
         default: begin e.kind = K_ILL; e.addr = 0; q.push_back(e); end
      endcase
   endtask

   // Called at posedge+2; waits (bounded) for READY, then offers w for one edge.
   task automatic send(input logic [15:0] w, output int acc);
      int n;
      n = 0;
      while (INSTR_READY !== 1'b1 && n < 100) begin
         @(posedge CLK); #2; n++;
      end
      if (INSTR_READY !== 1'b1) begin
         checks++; errors++;
         $display("FAIL send_timeout: READY=%b expected 1 within 100 cycles", INSTR_READY);
         acc = -1;
         return;
      end
      INSTR_IN = w; INSTR_VALID = 1'b1;
      acc = cyc;
      model(w, cyc + 2);
      @(posedge CLK); #2;
      INSTR_VALID = 1'b0;
      INSTR_IN    = 16'($urandom);
   endtask

   task automatic step(input int n);
      repeat (n) begin @(posedge CLK); #2; end
   endtask

   task automatic chk_all_zero(input string name);
      chk(name, {INSTR_READY, ISSUE_VALID, AR_EN, BR_EN, ALU_EN, INPUT_EN, WREN,
                 ALU_OP, ADDR, ILLEGAL, HALTED}, 32'h0);
   endtask

   // Monitor: compare whatever the DUT presents against the queue head.
   initial forever begin
      @(negedge CLK);
      if (RST === 1'b1) halt_seen = 0;
      else if (mon_en) begin
         logic [4:0] s;
         s = {AR_EN, BR_EN, ALU_EN, INPUT_EN, WREN};
         if (ISSUE_VALID) begin
            beat_cycles++;
            if (q.size() == 0 || q[0].kind != K_BEAT) begin
               checks++; errors++;
               $display("FAIL unexpected_beat: strobes=%b addr=%0h, none expected", s, ADDR);
            end else begin
               chk("beat_strobes", 32'(s), 32'(q[0].stb));
               chk("beat_alu_op", 32'(ALU_OP), 32'(q[0].op));
               chk("beat_addr", 32'(ADDR), 32'(q[0].addr));
               if (q[0].due >= 0) begin
                  chk("beat1_latency", cyc, q[0].due);
                  q[0].due = -1;
               end
               if (!STALL) void'(q.pop_front());
            end
         end else begin
            chk("quiet_outputs_zero", {s, ALU_OP, ADDR}, 32'h0);
         end
         if (ILLEGAL) begin
            if (q.size() == 0 || q[0].kind != K_ILL) begin
               checks++; errors++;
               $display("FAIL unexpected_illegal: ILLEGAL=1, not expected");
            end else begin
               chk("illegal_latency", cyc, q[0].due);
               void'(q.pop_front());
            end
         end
         if (HALTED && !halt_seen) begin
            halt_seen = 1;
            if (q.size() == 0 || q[0].kind != K_HALT) begin
               checks++; errors++;
               $display("FAIL unexpected_halt: HALTED=1, not expected");
            end else begin
               chk("halt_latency", cyc, q[0].due);
               void'(q.pop_front());
            end
         end
      end
   end

   // Random STALL, only while the random phase owns it.
   initial forever begin
      @(posedge CLK); #2;
      if (rnd_stall) STALL = ($urandom_range(0, 3) == 0);
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int k, b0;
      logic [3:0] op;
      RST = 1'b1; INSTR_VALID = 1'b0; INSTR_IN = '0; STALL = 1'b0;
      step(2);
      chk_all_zero("reset_outputs");
      RST = 1'b0; mon_en = 1;
      step(1);
      chk("ready_after_reset", 32'(INSTR_READY), 32'h1);

      // LDA: beat in cycle 2 only, READY back in cycle 3.
      send(16'h12AB, k);
      step(1);
      chk("lda_ready_busy", 32'(INSTR_READY), 32'h0);
      step(1);
      chk("lda_ready_back", 32'(INSTR_READY), 32'h1);

      // ADD: two beats, READY back after 4 cycles.
      send(16'h3000, k);
      step(2);
      chk("add_ready_busy", 32'(INSTR_READY), 32'h0);
      step(1);
      chk("add_ready_back", 32'(INSTR_READY), 32'h1);

      // ST held by a 3-cycle stall: exactly 4 visible cycles, one write.
      b0 = beat_cycles;
      send(16'h60FF, k);
      step(1);
      STALL = 1'b1;
      step(3);
      STALL = 1'b0;
      step(3);
      chk("st_stall_hold_cycles", beat_cycles - b0, 4);

      // Illegal opcode followed by IN.
      send(16'hA123, k);
      send(16'h5000, k);
      step(4);

      // HALT ignores further instructions until reset.
      send(16'h7000, k);
      INSTR_VALID = 1'b1; INSTR_IN = 16'h1111;
      for (int i = 0; i < 20; i++) begin
         step(1);
         chk("halt_ready_low", 32'(INSTR_READY), 32'h0);
         chk("halt_halted", 32'(HALTED), 32'h1);
      end
      INSTR_VALID = 1'b0;
      RST = 1'b1;
      step(1);
      RST = 1'b0;
      chk_all_zero("halt_reset_outputs");
      step(1);
      chk("halt_reset_ready", 32'(INSTR_READY), 32'h1);

      // Reset during a stalled SUB beat 1: beat 2 must never appear.
      send(16'h4123, k);
      step(1);
      STALL = 1'b1;
      step(1);
      RST = 1'b1;
      q.delete();
      step(1);
      RST = 1'b0; STALL = 1'b0;
      chk_all_zero("sub_reset_outputs");
      step(10);
      chk("sub_reset_ready", 32'(INSTR_READY), 32'h1);

      // Randomized traffic with random stalls.
      rnd_stall = 1;
      for (int i = 0; i < 150; i++) begin
         step($urandom_range(0, 2));
         do op = 4'($urandom_range(0, 15)); while (op == 4'd7);
         send({op, 12'($urandom)}, k);
      end
      rnd_stall = 0; STALL = 1'b0;
      step(20);
      chk("queue_drained", q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
